// File: rtl/simon_engine_param.sv
// Parametrised Simon game engine: WIDTH buttons, DEPTH-entry pattern memory, win/lose flags.
// Optional reply timeout enabled by defining SIMON_TIMEOUT_EN.
module simon_engine_param #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       step,
  input  logic                       level,
  input  logic [WIDTH-1:0]           pattern,
  output logic [WIDTH-1:0]           pattern_leds,
  output logic [2:0]                 mode_leds,
  output logic [$clog2(DEPTH+1)-1:0] seq_len,
  output logic                       win,
  output logic                       lose
);

  localparam int unsigned IW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [IW-1:0] NS_MAX = IW'(DEPTH);

  localparam logic [2:0] ModeInput    = 3'b001;
  localparam logic [2:0] ModePlayback = 3'b010;
  localparam logic [2:0] ModeRepeat   = 3'b100;
  localparam logic [2:0] ModeDone     = 3'b111;

  typedef enum logic [1:0] {StInput, StPlayback, StRepeat, StDone} state_e;

  state_e          state;
  logic [IW-1:0]   ns;
  logic [IW-1:0]   i;
  logic            level_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic            legal;
  logic            last;
  logic            match;
  logic [WIDTH-1:0] mem_rd;
  logic            mem_we;

`ifdef SIMON_TIMEOUT_EN
  logic [31:0]     tcnt;
`endif

  assign mem_rd  = mem[i[AW-1:0]];
  assign legal   = level_q ? $onehot(pattern) : (|pattern);
  assign last    = (i == ns - IW'(1));
  assign match   = (pattern == mem_rd);
  assign mem_we  = step && !rst && (state == StInput) && legal;
  assign seq_len = ns;

  // Memory has no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ns[AW-1:0]] <= pattern;
  end

  always_comb begin
    pattern_leds = pattern;
    unique case (state)
      StInput, StRepeat:   pattern_leds = pattern;
      StPlayback, StDone:  pattern_leds = mem_rd;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StInput;
      ns        <= '0;
      i         <= '0;
      win       <= 1'b0;
      lose      <= 1'b0;
      mode_leds <= ModeInput;
      level_q   <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      // Difficulty is latched only before the first entry is stored.
      if (state == StInput && ns == '0) level_q <= level;
`ifdef SIMON_TIMEOUT_EN
      if (state == StRepeat) tcnt <= tcnt + 32'd1;
`endif
      if (step) begin
        unique case (state)
          StInput: begin
            if (legal) begin
              ns        <= ns + IW'(1);
              i         <= '0;
              state     <= StPlayback;
              mode_leds <= ModePlayback;
            end
          end
          StPlayback: begin
            if (last) begin
              i         <= '0;
              state     <= StRepeat;
              mode_leds <= ModeRepeat;
`ifdef SIMON_TIMEOUT_EN
              tcnt      <= '0;
`endif
            end else begin
              i <= i + IW'(1);
            end
          end
          StRepeat: begin
`ifdef SIMON_TIMEOUT_EN
            tcnt <= '0;
`endif
            if (legal) begin
              if (!match) begin
                lose      <= 1'b1;
                i         <= '0;
                state     <= StDone;
                mode_leds <= ModeDone;
              end else if (!last) begin
                i <= i + IW'(1);
              end else if (ns == NS_MAX) begin
                win       <= 1'b1;
                i         <= '0;
                state     <= StDone;
                mode_leds <= ModeDone;
              end else begin
                i         <= '0;
                state     <= StInput;
                mode_leds <= ModeInput;
              end
            end
          end
          StDone: begin
            i <= last ? '0 : i + IW'(1);
          end
        endcase
      end
`ifdef SIMON_TIMEOUT_EN
      // A step in the expiry cycle takes priority over the timeout.
      else if (state == StRepeat && tcnt == 32'(TIMEOUT_CYC - 1)) begin
        lose      <= 1'b1;
        i         <= '0;
        state     <= StDone;
        mode_leds <= ModeDone;
      end
`endif
    end
  end

endmodule

// File: tb/tb_simon_engine_param.sv
// Directed bench for simon_engine_param (DEPTH=3, TIMEOUT_CYC=8): vector table plus
// hand sequences for mid-game reset and reply timeout.
module tb_simon_engine_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step = 1'b0;
  logic       level = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic [3:0] pattern_leds;
  logic [2:0] mode_leds;
  logic [1:0] seq_len;
  logic       win;
  logic       lose;

  int checks = 0;
  int errors = 0;

  simon_engine_param #(
    .WIDTH      (4),
    .DEPTH      (3),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .step        (step),
    .level       (level),
    .pattern     (pattern),
    .pattern_leds(pattern_leds),
    .mode_leds   (mode_leds),
    .seq_len     (seq_len),
    .win         (win),
    .lose        (lose)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       step;
    logic       level;
    logic [3:0] pat;
    logic [2:0] mode;
    logic [3:0] leds;
    logic [1:0] ns;
    logic       win;
    logic       lose;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic r, logic s, logic l, logic [3:0] p, logic [2:0] m,
                             logic [3:0] ld, logic [1:0] n, logic w, logic lo);
    vec_t t;
    t.rst = r; t.step = s; t.level = l; t.pat = p; t.mode = m;
    t.leds = ld; t.ns = n; t.win = w; t.lose = lo;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(string tag, logic [2:0] m, logic [1:0] n, logic w, logic lo);
    check({tag, " mode"}, 32'(mode_leds), 32'(m));
    check({tag, " ns"}, 32'(seq_len), 32'(n));
    check({tag, " win"}, 32'(win), 32'(w));
    check({tag, " lose"}, 32'(lose), 32'(lo));
  endtask

  task automatic do_step(logic [3:0] p);
    @(negedge clk);
    step = 1'b1;
    pattern = p;
    @(posedge clk);
    #1;
    step = 1'b0;
  endtask

  task automatic do_reset(logic l);
    @(negedge clk);
    rst = 1'b1;
    step = 1'b0;
    level = l;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst step level pat | mode leds ns win lose
    // Illegal two-bit pattern in hard mode, then first easy round.
    vecs.push_back(v(1, 0, 1, 4'b0011, 3'b001, 4'b0011, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 4'b0011, 3'b001, 4'b0011, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 4'b0011, 3'b001, 4'b0011, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0011, 3'b001, 4'b0011, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0011, 3'b010, 4'b0011, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0000, 3'b100, 4'b0000, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0011, 3'b100, 4'b0011, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0011, 3'b001, 4'b0011, 1, 0, 0));
    // Build {0001,0100}, reply 0001 then 1000 -> lose, DONE replays.
    vecs.push_back(v(1, 0, 0, 4'b0001, 3'b001, 4'b0001, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 4'b0001, 3'b001, 4'b0001, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0001, 3'b010, 4'b0001, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0001, 3'b100, 4'b0001, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0001, 3'b001, 4'b0001, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0100, 3'b010, 4'b0001, 2, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0100, 3'b010, 4'b0100, 2, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0100, 3'b100, 4'b0100, 2, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0001, 3'b100, 4'b0001, 2, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b1000, 3'b111, 4'b0001, 2, 0, 1));
    vecs.push_back(v(0, 1, 0, 4'b1000, 3'b111, 4'b0100, 2, 0, 1));
    vecs.push_back(v(0, 1, 0, 4'b1000, 3'b111, 4'b0001, 2, 0, 1));
    vecs.push_back(v(0, 0, 0, 4'b1000, 3'b111, 4'b0001, 2, 0, 1));
    // Hard mode full game to DEPTH=3 -> win; level frozen once ns>0.
    vecs.push_back(v(1, 0, 1, 4'b0001, 3'b001, 4'b0001, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 4'b0001, 3'b001, 4'b0001, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 4'b0001, 3'b010, 4'b0001, 1, 0, 0));
    vecs.push_back(v(0, 1, 1, 4'b0001, 3'b100, 4'b0001, 1, 0, 0));
    vecs.push_back(v(0, 1, 1, 4'b0001, 3'b001, 4'b0001, 1, 0, 0));
    vecs.push_back(v(0, 1, 1, 4'b0010, 3'b010, 4'b0001, 2, 0, 0));
    vecs.push_back(v(0, 1, 1, 4'b0010, 3'b010, 4'b0010, 2, 0, 0));
    vecs.push_back(v(0, 1, 1, 4'b0010, 3'b100, 4'b0010, 2, 0, 0));
    vecs.push_back(v(0, 1, 1, 4'b0001, 3'b100, 4'b0001, 2, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0011, 3'b100, 4'b0011, 2, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0010, 3'b001, 4'b0010, 2, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b1000, 3'b010, 4'b0001, 3, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b1000, 3'b010, 4'b0010, 3, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b1000, 3'b010, 4'b1000, 3, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b1000, 3'b100, 4'b1000, 3, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0001, 3'b100, 4'b0001, 3, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0010, 3'b100, 4'b0010, 3, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b0110, 3'b100, 4'b0110, 3, 0, 0));
    vecs.push_back(v(0, 1, 0, 4'b1000, 3'b111, 4'b0001, 3, 1, 0));
    vecs.push_back(v(0, 0, 0, 4'b1000, 3'b111, 4'b0001, 3, 1, 0));

    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst;
      step = vecs[k].step;
      level = vecs[k].level;
      pattern = vecs[k].pat;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d leds", k), 32'(pattern_leds), 32'(vecs[k].leds));
      check_state($sformatf("vec%0d", k), vecs[k].mode, vecs[k].ns, vecs[k].win, vecs[k].lose);
    end
    @(negedge clk);
    step = 1'b0;

    // Mid-game asynchronous reset during PLAYBACK with ns=3.
    do_reset(1'b0);
    do_step(4'b0001); do_step(4'b0001); do_step(4'b0001);
    do_step(4'b0010); do_step(4'b0010); do_step(4'b0010);
    do_step(4'b0001); do_step(4'b0010);
    do_step(4'b0100); do_step(4'b0100);
    check_state("pre-rst", 3'b010, 2'd3, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    step = 1'b1;
    rst = 1'b1;
    #1;
    check_state("async-rst", 3'b001, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_state("rst-held", 3'b001, 2'd0, 1'b0, 1'b0);
    step = 1'b0;
    rst = 1'b0;

    // Reply timeout: 8 idle cycles in REPEAT.
    do_reset(1'b0);
    do_step(4'b0001);
    do_step(4'b0001);
    repeat (7) @(posedge clk);
    #1;
    check_state("to-idle7", 3'b100, 2'd1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
`ifdef SIMON_TIMEOUT_EN
    check_state("to-idle8", 3'b111, 2'd1, 1'b0, 1'b1);
`else
    check_state("to-idle8", 3'b100, 2'd1, 1'b0, 1'b0);
`endif

    // Step on the expiry cycle beats the timeout.
    do_reset(1'b0);
    do_step(4'b0001);
    do_step(4'b0001);
    repeat (7) @(posedge clk);
    do_step(4'b0001);
    check_state("to-step8", 3'b001, 2'd1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
